// File: rtl/uart_cmd_responder.sv
// Knight-side UART command responder: 8N1 receiver that pairs bytes
// (high byte first) into a 16-bit command, plus an 8N1 response transmitter.
module uart_cmd_responder #(
    parameter int unsigned BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        trmt,
    output logic        tx_done
);

    localparam int unsigned      CNT_W     = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic       {PAIR_HIGH, PAIR_LOW}                  pair_state_e;
    typedef enum logic       {TX_IDLE, TX_XMIT}                     tx_state_e;

    // ---------------- RX path ----------------
    logic             rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [3:0]       rx_bit_cnt_q;
    logic [7:0]       rx_shift_q;
    logic             rx_fall_c, rx_cnt_done_c;
    logic             rx_load_half_c, rx_load_full_c, rx_shift_c;
    logic             rx_byte_vld_c, rx_frm_err_c;

    assign rx_fall_c     = rx_prev_q & ~rx_sync_q;
    assign rx_cnt_done_c = (rx_cnt_q == '0);

    // RX double-flop synchronizer plus edge-detect history, preset to idle-high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // RX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state_q <= RX_IDLE;
        else        rx_state_q <= rx_state_d;
    end

    // RX next-state: start qualification, 8 data bits, stop-bit middle
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_fall_c) rx_state_d = RX_START;
            RX_START: if (rx_cnt_done_c) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_cnt_done_c && rx_bit_cnt_q == 4'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_cnt_done_c) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX controls: counter loads, data shift, byte-valid / framing-error pulses
    always_comb begin
        rx_load_half_c = 1'b0;
        rx_load_full_c = 1'b0;
        rx_shift_c     = 1'b0;
        rx_byte_vld_c  = 1'b0;
        rx_frm_err_c   = 1'b0;
        case (rx_state_q)
            RX_IDLE:  rx_load_half_c = rx_fall_c;
            RX_START: rx_load_full_c = rx_cnt_done_c & ~rx_sync_q;
            RX_DATA: begin
                rx_shift_c     = rx_cnt_done_c;
                rx_load_full_c = rx_cnt_done_c;
            end
            RX_STOP: begin
                rx_byte_vld_c = rx_cnt_done_c & rx_sync_q;
                rx_frm_err_c  = rx_cnt_done_c & ~rx_sync_q;
            end
            default: ;
        endcase
    end

    // RX baud counter, bit counter and LSB-first shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt_q     <= '0;
            rx_bit_cnt_q <= 4'd0;
            rx_shift_q   <= 8'h00;
        end else begin
            if (rx_load_half_c)      rx_cnt_q <= HALF_LOAD;
            else if (rx_load_full_c) rx_cnt_q <= FULL_LOAD;
            else if (!rx_cnt_done_c) rx_cnt_q <= rx_cnt_q - CNT_ONE;

            if (rx_load_half_c)  rx_bit_cnt_q <= 4'd0;
            else if (rx_shift_c) rx_bit_cnt_q <= rx_bit_cnt_q + 4'd1;

            if (rx_shift_c) rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
        end
    end

    // ---------------- Byte-pair assembly ----------------
    pair_state_e pair_q, pair_d;
    logic [7:0]  cmd_hi_q;
    logic [15:0] cmd_q;
    logic        cmd_rdy_q;
    logic        ld_hi_c, ld_cmd_c;

    // Pair state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pair_q <= PAIR_HIGH;
        else        pair_q <= pair_d;
    end

    // Pair next-state: alternate on valid bytes, resync to HIGH on framing error
    always_comb begin
        pair_d = pair_q;
        if (rx_frm_err_c)       pair_d = PAIR_HIGH;
        else if (rx_byte_vld_c) pair_d = (pair_q == PAIR_HIGH) ? PAIR_LOW : PAIR_HIGH;
    end

    // Pair controls: capture high byte or complete the command
    always_comb begin
        ld_hi_c  = 1'b0;
        ld_cmd_c = 1'b0;
        if (rx_byte_vld_c) begin
            ld_hi_c  = (pair_q == PAIR_HIGH);
            ld_cmd_c = (pair_q == PAIR_LOW);
        end
    end

    // Command registers; completion outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_hi_q  <= 8'h00;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
        end else begin
            if (ld_hi_c)  cmd_hi_q <= rx_shift_q;
            if (ld_cmd_c) cmd_q    <= {cmd_hi_q, rx_shift_q};
            if (ld_cmd_c)                    cmd_rdy_q <= 1'b1;
            else if (clr_cmd_rdy || ld_hi_c) cmd_rdy_q <= 1'b0;
        end
    end

    // ---------------- TX path ----------------
    tx_state_e        tx_state_q, tx_state_d;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_bit_cnt_q;
    logic [9:0]       tx_shift_q;
    logic             tx_q, tx_done_q;
    logic             tx_cnt_done_c, tx_load_c, tx_bit_end_c, tx_finish_c;

    assign tx_cnt_done_c = (tx_cnt_q == '0);

    // TX state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state_q <= TX_IDLE;
        else        tx_state_q <= tx_state_d;
    end

    // TX next-state: trmt only honoured while idle
    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            TX_IDLE: if (trmt) tx_state_d = TX_XMIT;
            TX_XMIT: if (tx_cnt_done_c && tx_bit_cnt_q == 4'd9) tx_state_d = TX_IDLE;
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // TX controls: frame load, bit boundary, end of stop bit
    always_comb begin
        tx_load_c    = 1'b0;
        tx_bit_end_c = 1'b0;
        tx_finish_c  = 1'b0;
        case (tx_state_q)
            TX_IDLE: tx_load_c = trmt;
            TX_XMIT: begin
                tx_bit_end_c = tx_cnt_done_c & (tx_bit_cnt_q != 4'd9);
                tx_finish_c  = tx_cnt_done_c & (tx_bit_cnt_q == 4'd9);
            end
            default: ;
        endcase
    end

    // TX datapath: 10-bit frame shifter, registered line and done flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt_q     <= '0;
            tx_bit_cnt_q <= 4'd0;
            tx_shift_q   <= 10'h3FF;
            tx_q         <= 1'b1;
            tx_done_q    <= 1'b0;
        end else if (tx_load_c) begin
            tx_shift_q   <= {1'b1, resp, 1'b0};
            tx_q         <= 1'b0;
            tx_cnt_q     <= FULL_LOAD;
            tx_bit_cnt_q <= 4'd0;
            tx_done_q    <= 1'b0;
        end else if (tx_bit_end_c) begin
            tx_shift_q   <= {1'b1, tx_shift_q[9:1]};
            tx_q         <= tx_shift_q[1];
            tx_cnt_q     <= FULL_LOAD;
            tx_bit_cnt_q <= tx_bit_cnt_q + 4'd1;
        end else if (tx_finish_c) begin
            tx_q      <= 1'b1;
            tx_done_q <= 1'b1;
        end else if (tx_state_q == TX_XMIT) begin
            tx_cnt_q <= tx_cnt_q - CNT_ONE;
        end
    end

    assign TX      = tx_q;
    assign tx_done = tx_done_q;
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: serial RX driver, TX frame checker and a
// byte-pairing reference model.
module tb_uart_cmd_responder;
    localparam int unsigned BAUD = 16;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    int n_tests;
    int n_fail;

    // reference model of the command link
    bit          m_have_hi;
    logic [7:0]  m_hi;
    logic [15:0] m_cmd;
    bit          m_rdy;

    uart_cmd_responder #(.BAUD_DIV(BAUD)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .trmt        (trmt),
        .tx_done     (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_have_hi = 1'b0;
        m_hi      = 8'h00;
        m_cmd     = 16'h0000;
        m_rdy     = 1'b0;
    endfunction

    function automatic void model_byte(input logic [7:0] b, input logic good);
        if (!good) begin
            m_have_hi = 1'b0;
        end else if (!m_have_hi) begin
            m_hi      = b;
            m_have_hi = 1'b1;
            m_rdy     = 1'b0;
        end else begin
            m_cmd     = {m_hi, b};
            m_rdy     = 1'b1;
            m_have_hi = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (BAUD) tick();
        end
        RX = 1'b1;
        repeat (gap) tick();
        model_byte(b, stop_bit);
    endtask

    task automatic pulse_clr();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
    endtask

    // transmit one response and check every bit period of the frame
    task automatic do_tx(input logic [7:0] r, input bit inject);
        logic [9:0] fr;
        int idx;
        fr = {1'b1, r, 1'b0};
        tick();
        resp = r;
        trmt = 1'b1;
        @(posedge clk);
        #1;
        trmt = 1'b0;
        resp = 8'($urandom);
        for (int i = 0; i < 10 * BAUD; i++) begin
            @(negedge clk);
            if (inject && i == 48) begin
                trmt = 1'b1;
                resp = ~r;
            end
            if (inject && i == 49) trmt = 1'b0;
            idx = i / BAUD;
            n_tests++;
            if (TX !== fr[idx]) begin
                n_fail++;
                $display("FAIL tx_bit clk %0d: TX=%b expected %b", i, TX, fr[idx]);
            end
            n_tests++;
            if (tx_done !== 1'b0) begin
                n_fail++;
                $display("FAIL tx_done_busy clk %0d: tx_done=%b expected 0", i, tx_done);
            end
        end
        @(negedge clk);
        n_tests++;
        if (tx_done !== 1'b1 || TX !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_end: tx_done=%b TX=%b expected 1 1", tx_done, TX);
        end
        if (inject) begin
            for (int i = 0; i < 2 * BAUD; i++) begin
                @(negedge clk);
                n_tests++;
                if (TX !== 1'b1 || tx_done !== 1'b1) begin
                    n_fail++;
                    $display("FAIL tx_no_restart clk %0d: TX=%b tx_done=%b expected 1 1", i, TX, tx_done);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        RX = 1'b1;
        trmt = 1'b0;
        clr_cmd_rdy = 1'b0;
        resp = 8'h00;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n_tests++;
            if (TX !== 1'b1 || cmd_rdy !== 1'b0 || tx_done !== 1'b0 || cmd !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_idle clk %0d: TX=%b cmd_rdy=%b tx_done=%b cmd=%h expected 1 0 0 0000",
                         i, TX, cmd_rdy, tx_done, cmd);
            end
        end
    endtask

    task automatic test_cmd_basic();
        send_byte(8'h2A, 1'b1, 4);
        n_tests++;
        if (cmd_rdy !== m_rdy || cmd !== m_cmd) begin
            n_fail++;
            $display("FAIL basic_high_only: cmd=%h rdy=%b expected %h %b", cmd, cmd_rdy, m_cmd, m_rdy);
        end
        send_byte(8'h13, 1'b1, 4);
        n_tests++;
        if (cmd !== 16'h2A13 || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pair: cmd=%h rdy=%b expected 2a13 1", cmd, cmd_rdy);
        end
        pulse_clr();
        n_tests++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h2A13) begin
            n_fail++;
            $display("FAIL basic_clr: cmd=%h rdy=%b expected 2a13 0", cmd, cmd_rdy);
        end
    endtask

    task automatic test_tx();
        do_tx(8'hA5, 1'b1);
        do_tx(8'($urandom), 1'b0);
    endtask

    task automatic test_glitch();
        RX = 1'b0;
        repeat (4) tick();
        RX = 1'b1;
        repeat (3 * BAUD) tick();
        n_tests++;
        if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
            n_fail++;
            $display("FAIL glitch_ignored: cmd=%h rdy=%b expected %h %b", cmd, cmd_rdy, m_cmd, m_rdy);
        end
        send_byte(8'h00, 1'b1, 3);
        send_byte(8'hFF, 1'b1, 3);
        n_tests++;
        if (cmd !== 16'h00FF || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_pair: cmd=%h rdy=%b expected 00ff 1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_framing();
        send_byte(8'h55, 1'b0, BAUD);
        n_tests++;
        if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
            n_fail++;
            $display("FAIL frame_err_drop: cmd=%h rdy=%b expected %h %b", cmd, cmd_rdy, m_cmd, m_rdy);
        end
        send_byte(8'h12, 1'b1, 2);
        n_tests++;
        if (cmd !== 16'h00FF || cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_resync_high: cmd=%h rdy=%b expected 00ff 0", cmd, cmd_rdy);
        end
        send_byte(8'h34, 1'b1, 2);
        n_tests++;
        if (cmd !== 16'h1234 || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_resync_pair: cmd=%h rdy=%b expected 1234 1", cmd, cmd_rdy);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            b = 8'($urandom);
            send_byte(b, 1'b1, 0);
            n_tests++;
            if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
                n_fail++;
                $display("FAIL b2b byte %0d: cmd=%h rdy=%b expected %h %b", k, cmd, cmd_rdy, m_cmd, m_rdy);
            end
        end
        RX = 1'b1;
        repeat (BAUD) tick();
    endtask

    task automatic test_random_pairs();
        logic [7:0] b;
        logic       good;
        int         gap;
        for (int k = 0; k < 14; k++) begin
            b    = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            gap  = good ? int'($urandom_range(0, 6)) : int'(BAUD);
            if ($urandom_range(0, 3) == 0) pulse_clr();
            send_byte(b, good, gap);
            n_tests++;
            if (cmd !== m_cmd || cmd_rdy !== m_rdy) begin
                n_fail++;
                $display("FAIL random byte %0d (%h stop=%b): cmd=%h rdy=%b expected %h %b",
                         k, b, good, cmd, cmd_rdy, m_cmd, m_rdy);
            end
        end
    endtask

    task automatic test_full_duplex();
        logic [7:0] hi, lo;
        hi = 8'($urandom);
        lo = 8'($urandom);
        fork
            do_tx(8'($urandom), 1'b0);
            begin
                send_byte(hi, 1'b1, 1);
                send_byte(lo, 1'b1, 1);
            end
        join
        n_tests++;
        if (cmd !== {hi, lo} || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL duplex_pair: cmd=%h rdy=%b expected %h 1", cmd, cmd_rdy, {hi, lo});
        end
    endtask

    task automatic test_clr_collision_and_reset();
        logic [7:0] hi, lo;
        logic [9:0] fr;
        bit seen;
        pulse_clr();
        hi = 8'($urandom);
        lo = 8'($urandom);
        send_byte(hi, 1'b1, 2);
        clr_cmd_rdy = 1'b1;
        seen = 1'b0;
        fork
            send_byte(lo, 1'b1, 2);
            for (int i = 0; i < 11 * BAUD; i++) begin
                @(negedge clk);
                if (cmd_rdy === 1'b1) seen = 1'b1;
            end
        join
        clr_cmd_rdy = 1'b0;
        m_rdy = 1'b0;
        tick();
        n_tests++;
        if (seen !== 1'b1 || cmd !== {hi, lo}) begin
            n_fail++;
            $display("FAIL set_beats_clr: seen_rdy=%b cmd=%h expected 1 %h", seen, cmd, {hi, lo});
        end
        n_tests++;
        if (cmd_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_after_set: rdy=%b expected 0", cmd_rdy);
        end

        // complete pair, then reset partway through the next frame
        send_byte(8'($urandom), 1'b1, 2);
        send_byte(8'($urandom), 1'b1, 2);
        n_tests++;
        if (cmd !== m_cmd || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_pair: cmd=%h rdy=%b expected %h 1", cmd, cmd_rdy, m_cmd);
        end
        fr = {1'b1, 8'($urandom), 1'b0};
        for (int i = 0; i < 5; i++) begin
            RX = fr[i];
            repeat (BAUD) tick();
        end
        repeat (BAUD / 2) tick();
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        n_tests++;
        if (cmd_rdy !== 1'b0 || cmd !== 16'h0000 || TX !== 1'b1 || tx_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_frame_reset: rdy=%b cmd=%h TX=%b tx_done=%b expected 0 0000 1 0",
                     cmd_rdy, cmd, TX, tx_done);
        end
        RX = 1'b1;
        tick();
        rst_n = 1'b1;
        repeat (12 * BAUD) tick();
        hi = 8'($urandom);
        lo = 8'($urandom);
        send_byte(hi, 1'b1, 2);
        send_byte(lo, 1'b1, 2);
        n_tests++;
        if (cmd !== {hi, lo} || cmd_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_pair: cmd=%h rdy=%b expected %h 1", cmd, cmd_rdy, {hi, lo});
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_cmd_basic();
        test_tx();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_random_pairs();
        test_full_duplex();
        test_clr_collision_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
